// File: rtl/gray_frame_controller.sv
`default_nettype none
// ============================================================================
// Module   : gray_frame_controller
// Purpose  : Frame-level sequencer for the Bayer-to-grayscale capture path;
//            arms on clean frame boundaries and tags pixels with coordinates.
// Revision : 1.0 - initial release
// ============================================================================
module gray_frame_controller #(
    parameter int H_ACTIVE     = 640,
    parameter int V_ACTIVE     = 480,
    parameter int FLUSH_CYCLES = 8,
    parameter int CLR_CYCLES   = 2
) (
    input  logic        iCLK,
    input  logic        iRST,
    input  logic        iFVAL,
    input  logic        iGrayDVAL,
    input  logic        iStart,
    input  logic        iStop,
    input  logic        iModeWr,
    input  logic [1:0]  iModeReq,
    input  logic        iErrClr,
    output logic        oPipeEn,
    output logic        oBufClr,
    output logic [1:0]  oMode,
    output logic        oPixVal,
    output logic [9:0]  oX,
    output logic [9:0]  oY,
    output logic        oSOF,
    output logic        oEOL,
    output logic        oEOF,
    output logic [15:0] oFrameCnt,
    output logic        oErr,
    output logic        oBusy
);

    localparam int c_CNT_W = $clog2(H_ACTIVE * V_ACTIVE + 1);
    localparam int c_FL_W  = (FLUSH_CYCLES > 2) ? $clog2(FLUSH_CYCLES) : 1;
    localparam int c_CL_W  = (CLR_CYCLES > 2) ? $clog2(CLR_CYCLES) : 1;

    localparam logic [2:0] c_IDLE     = 3'd0;
    localparam logic [2:0] c_ARM      = 3'd1;
    localparam logic [2:0] c_WAIT_SOF = 3'd2;
    localparam logic [2:0] c_ACTIVE   = 3'd3;
    localparam logic [2:0] c_FLUSH    = 3'd4;
    localparam logic [2:0] c_CLEAR    = 3'd5;

    localparam logic [9:0]         c_X_LAST  = 10'(H_ACTIVE - 1);
    localparam logic [9:0]         c_Y_LAST  = 10'(V_ACTIVE - 1);
    localparam logic [c_CNT_W-1:0] c_TOTAL   = c_CNT_W'(H_ACTIVE * V_ACTIVE);
    localparam logic [c_FL_W-1:0]  c_FL_LAST = c_FL_W'(FLUSH_CYCLES - 1);
    localparam logic [c_CL_W-1:0]  c_CL_LAST = c_CL_W'(CLR_CYCLES - 1);

    logic [2:0]         r_state;
    logic [2:0]         w_state_nxt;
    logic               r_fval_q;
    logic [9:0]         r_x;
    logic [9:0]         r_y;
    logic               r_done;
    logic [c_CNT_W-1:0] r_pix_cnt;
    logic [c_FL_W-1:0]  r_flush_cnt;
    logic [c_CL_W-1:0]  r_clr_cnt;
    logic               r_stop_pend;
    logic [1:0]         r_mode_pend;

    logic               w_rise;
    logic               w_fall;
    logic               w_window;
    logic               w_accept;
    logic               w_overrun;
    logic               w_flush_last;
    logic               w_clr_last;
    logic               w_count_bad;
    logic [1:0]         w_mode_req;

    assign w_rise       = iFVAL & ~r_fval_q;
    assign w_fall       = ~iFVAL & r_fval_q;
    assign w_window     = (r_state == c_ACTIVE) || (r_state == c_FLUSH);
    assign w_accept     = w_window & iGrayDVAL & ~r_done;
    assign w_overrun    = w_window & iGrayDVAL & r_done;
    assign w_flush_last = (r_state == c_FLUSH) && (r_flush_cnt == c_FL_LAST);
    assign w_clr_last   = (r_state == c_CLEAR) && (r_clr_cnt == c_CL_LAST);
    // A pixel landing in the last flush cycle still counts toward the total.
    assign w_count_bad  = w_flush_last &&
                          ((r_pix_cnt + c_CNT_W'(w_accept)) != c_TOTAL);
    assign w_mode_req   = (iModeReq == 2'd3) ? 2'd0 : iModeReq;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (iStart) w_state_nxt = c_ARM;
            end
            c_ARM: begin
                if (iStop)       w_state_nxt = c_IDLE;
                else if (!iFVAL) w_state_nxt = c_WAIT_SOF;
            end
            c_WAIT_SOF: begin
                if (iStop)       w_state_nxt = c_IDLE;
                else if (w_rise) w_state_nxt = c_ACTIVE;
            end
            c_ACTIVE: begin
                if (w_fall) w_state_nxt = c_FLUSH;
            end
            c_FLUSH: begin
                if (w_flush_last) w_state_nxt = c_CLEAR;
            end
            c_CLEAR: begin
                if (w_clr_last)
                    w_state_nxt = (r_stop_pend | iStop) ? c_IDLE : c_WAIT_SOF;
            end
            default: w_state_nxt = c_IDLE;
        endcase
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state     <= c_IDLE;
            r_fval_q    <= 1'b0;
            r_x         <= '0;
            r_y         <= '0;
            r_done      <= 1'b0;
            r_pix_cnt   <= '0;
            r_flush_cnt <= '0;
            r_clr_cnt   <= '0;
            r_stop_pend <= 1'b0;
            r_mode_pend <= 2'd0;
            oPipeEn     <= 1'b0;
            oBufClr     <= 1'b0;
            oMode       <= 2'd0;
            oPixVal     <= 1'b0;
            oX          <= '0;
            oY          <= '0;
            oSOF        <= 1'b0;
            oEOL        <= 1'b0;
            oEOF        <= 1'b0;
            oFrameCnt   <= '0;
            oErr        <= 1'b0;
            oBusy       <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_fval_q <= iFVAL;

            oPipeEn <= (w_state_nxt == c_ACTIVE) || (w_state_nxt == c_FLUSH);
            oBufClr <= (w_state_nxt == c_CLEAR);
            oBusy   <= (w_state_nxt != c_IDLE);

            // Position counters hold at the last pixel; later pixels are overruns.
            if (r_state == c_WAIT_SOF) begin
                r_x       <= '0;
                r_y       <= '0;
                r_done    <= 1'b0;
                r_pix_cnt <= '0;
            end else if (w_accept) begin
                r_pix_cnt <= r_pix_cnt + c_CNT_W'(1);
                if (r_x == c_X_LAST) begin
                    if (r_y == c_Y_LAST) begin
                        r_done <= 1'b1;
                    end else begin
                        r_x <= '0;
                        r_y <= r_y + 10'd1;
                    end
                end else begin
                    r_x <= r_x + 10'd1;
                end
            end

            oPixVal <= w_accept;
            oSOF    <= w_accept && (r_x == 10'd0) && (r_y == 10'd0);
            oEOL    <= w_accept && (r_x == c_X_LAST);
            oEOF    <= w_accept && (r_x == c_X_LAST) && (r_y == c_Y_LAST);
            if (w_accept) begin
                oX <= r_x;
                oY <= r_y;
            end

            r_flush_cnt <= (r_state == c_FLUSH) ? r_flush_cnt + c_FL_W'(1) : '0;
            r_clr_cnt   <= (r_state == c_CLEAR) ? r_clr_cnt + c_CL_W'(1) : '0;

            if (w_flush_last) begin
                oFrameCnt <= oFrameCnt + 16'd1;
            end

            if (w_state_nxt == c_IDLE) begin
                r_stop_pend <= 1'b0;
            end else if (iStop && (r_state != c_IDLE)) begin
                r_stop_pend <= 1'b1;
            end

            // Idle writes take effect at once; otherwise they wait for CLEAR.
            if (iModeWr) begin
                r_mode_pend <= w_mode_req;
            end
            if (r_state == c_IDLE) begin
                if (iModeWr) oMode <= w_mode_req;
            end else if (r_state == c_CLEAR) begin
                oMode <= r_mode_pend;
            end

            if (w_overrun || w_count_bad) begin
                oErr <= 1'b1;
            end else if (iErrClr) begin
                oErr <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire
